// File: rtl/dec2stch_bank_if.sv
// Load/run handshake and stream bus of the decimal-to-stochastic bank.
// The bank drives the slave side and the channel values are driven on the master side.
interface dec2stch_bank_if #(
  parameter int NCH = 4,
  parameter int ND  = 8,
  parameter int LEN = 255
);
  localparam int CW = $clog2(LEN + 1);

  logic [NCH*ND-1:0] d_in;
  logic              load_valid;
  logic              load_ready;
  logic              abort;
  logic [NCH-1:0]    s;
  logic              s_valid;
  logic              done;
  logic [NCH*CW-1:0] cnt;

  modport master (
    output d_in, load_valid, abort,
    input  load_ready, s, s_valid, done, cnt
  );

  modport slave (
    input  d_in, load_valid, abort,
    output load_ready, s, s_valid, done, cnt
  );
endinterface

// File: rtl/dec2stch_bank.sv
// Multi-channel decimal-to-stochastic converter: one shared maximal-length LFSR,
// per-channel rotated comparison, ones counters and a load/run/done handshake.
//
// state | meaning
// IDLE  | load_ready high, waiting for load_valid; clears stream outputs
// RUN   | one stream bit per cycle until the terminal count or abort
module dec2stch_bank #(
  parameter int          NCH  = 4,
  parameter int          ND   = 8,
  parameter int          LEN  = 255,
  parameter logic [15:0] SEED = 16'h00B5
) (
  input logic            clk_i,
  input logic            init_i,
  dec2stch_bank_if.slave bus
);
  localparam int CW = $clog2(LEN + 1);

  function automatic logic [15:0] tap_mask(input int n);
    case (n)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]   TAPS     = tap_mask(ND);
  localparam logic [ND-1:0] SEED_RAW = SEED[ND-1:0];
  localparam logic [ND-1:0] SEED_M   = (SEED_RAW == '0) ? ND'(1) : SEED_RAW;

  generate
    if (TAPS == 16'h0000) begin : g_bad_nd
      $error("dec2stch_bank: ND must be 4..12 or 16");
    end
    if (LEN < 1 || LEN > 65535) begin : g_bad_len
      $error("dec2stch_bank: LEN must be 1..65535");
    end
  endgenerate

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ND-1:0]     lfsr_q, lfsr_d, lfsr_nxt;
  logic [CW-1:0]     rem_q, rem_d;
  logic [NCH*ND-1:0] dreg_q, dreg_d;
  logic [NCH-1:0]    s_q, s_d, cmp;
  logic              sv_q, sv_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic [NCH*CW-1:0] cnt_q, cnt_d;

  assign lfsr_nxt = {lfsr_q[ND-2:0], ^(lfsr_q & TAPS[ND-1:0])};

  // Rotating the shared state per channel decorrelates the streams while
  // keeping each channel's sample sequence a permutation of 1..2^ND-1.
  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      localparam int R = k % ND;
      logic [ND-1:0] rot;
      assign rot    = (R == 0) ? lfsr_q : ((lfsr_q << R) | (lfsr_q >> (ND - R)));
      assign cmp[k] = (dreg_q[k*ND +: ND] >= rot);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    rem_d   = rem_q;
    dreg_d  = dreg_q;
    s_d     = s_q;
    sv_d    = sv_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        s_d     = '0;
        sv_d    = 1'b0;
        if (bus.load_valid && ready_q) begin
          dreg_d  = bus.d_in;
          lfsr_d  = SEED_M;
          rem_d   = CW'(LEN - 1);
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          s_d     = '0;
          sv_d    = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          s_d    = cmp;
          sv_d   = 1'b1;
          lfsr_d = lfsr_nxt;
          rem_d  = rem_q - CW'(1);
          for (int k = 0; k < NCH; k++) begin
            cnt_d[k*CW +: CW] = cnt_q[k*CW +: CW] + CW'(cmp[k]);
          end
          if (rem_q == '0) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!init_i) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED_M;
      rem_q   <= '0;
      dreg_q  <= '0;
      s_q     <= '0;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rem_q   <= rem_d;
      dreg_q  <= dreg_d;
      s_q     <= s_d;
      sv_q    <= sv_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.s          = s_q;
  assign bus.s_valid    = sv_q;
  assign bus.done       = done_q;
  assign bus.cnt        = cnt_q;
endmodule
